// File: rtl/fp_mul_arbiter_pkg.sv
// Shared types and helpers for the fp_mul_arbiter slice.
//   fp_word_t   : default-width FP word (sign|exp|mantissa), carried unmodified
//   arb_state_e : halt/drain sequencing states
//   rr_pick     : round-robin winner search over up to MAX_REQ requesters
package fp_arb_pkg;

  localparam int unsigned FP_WIDTH = 32;
  localparam int unsigned MAX_REQ  = 8;
  localparam int unsigned MAX_IDW  = 3;

  typedef logic [FP_WIDTH-1:0] fp_word_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic               found;
    logic [MAX_IDW-1:0] idx;
  } pick_t;

  // First set bit of valid[n-1:0], scanning upward from (ptr+1) mod n with wrap.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [MAX_IDW-1:0] ptr,
                                    input int unsigned        n);
    pick_t       p;
    int unsigned idx;
    p = '0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      if (k <= n) begin
        idx = (32'(ptr) + k) % n;
        if (!p.found && valid[idx[MAX_IDW-1:0]]) begin
          p.found = 1'b1;
          p.idx   = idx[MAX_IDW-1:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/fp_mul_arbiter_if.sv
// Bundle of request, multiplier and response signals for fp_mul_arbiter.
//   slave  : arbiter side (consumes requests/mul_result/halt_req)
//   master : environment side (requesters + shared multiplier + control)
interface fp_mul_arbiter_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     mul_valid;
  logic [WIDTH-1:0]         mul_a;
  logic [WIDTH-1:0]         mul_b;
  logic [WIDTH-1:0]         mul_result;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]         rsp_data;
  logic                     halt_req;
  logic                     halted;
  logic                     busy;

  modport slave (
    input  req_valid, req_a, req_b, mul_result, halt_req,
    output req_ready, mul_valid, mul_a, mul_b, rsp_valid, rsp_data, halted, busy
  );

  modport master (
    output req_valid, req_a, req_b, mul_result, halt_req,
    input  req_ready, mul_valid, mul_a, mul_b, rsp_valid, rsp_data, halted, busy
  );
endinterface

// File: rtl/fp_arb_tag_pipe.sv
// Owner-tracking shift register: LAT stages of {vld, id} running alongside
// the shared multiplier so each result can be routed back to its requester.
//   clk, reset (sync, active-low) | in_vld/in_id : stage-0 load
//   out_vld/out_id : last stage   | any_vld      : OR of all stage valids
module fp_arb_tag_pipe #(
  parameter int unsigned IDW = 2,
  parameter int unsigned LAT = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_vld,
  input  logic [IDW-1:0] in_id,
  output logic           out_vld,
  output logic [IDW-1:0] out_id,
  output logic           any_vld
);

  logic [LAT-1:0] vld_q;
  logic [IDW-1:0] id_q [LAT];

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < LAT; i++) id_q[i] <= '0;
    end else begin
      vld_q[0] <= in_vld;
      id_q[0]  <= in_id;
      for (int unsigned i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
    end
  end

  assign out_vld = vld_q[LAT-1];
  assign out_id  = id_q[LAT-1];
  assign any_vld = |vld_q;

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one fixed-latency FP multiplier between NUM_REQ requesters.
// One grant per cycle (round-robin), owner tracked through MUL_LAT stages,
// result routed back as a one-hot rsp_valid. halt_req drains and quiesces.
//   clk, reset (sync, active-low)
//   bus (fp_mul_arbiter_if.slave): req_*, mul_*, rsp_*, halt_req, halted, busy
// Build option: FP_MUL_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
// wins, no rr_ptr) instead of round-robin.
module fp_mul_arbiter
  import fp_arb_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  fp_mul_arbiter_if.slave bus
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  arb_state_e     state_q, state_d;
  logic           grant_en, found, accept;
  logic [IDW-1:0] win;
  logic           last_vld, any_vld;
  logic [IDW-1:0] last_id;

`ifdef FP_MUL_ARB_FIXED_PRIO_EN
  // Scan downward so the lowest requesting index is the final assignment.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      if (bus.req_valid[i-1]) begin
        found = 1'b1;
        win   = IDW'(i-1);
      end
    end
  end
`else
  logic [IDW-1:0] rr_ptr;
  pick_t          pick;

  always_comb begin
    pick  = rr_pick(MAX_REQ'(bus.req_valid), MAX_IDW'(rr_ptr), NUM_REQ);
    found = pick.found;
    win   = pick.idx[IDW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset)      rr_ptr <= IDW'(NUM_REQ-1);
    else if (accept) rr_ptr <= win;
  end
`endif

  // Outputs are held at 0 while reset is asserted, not only after the edge.
  assign grant_en = reset && (state_q == RUN);
  assign accept   = grant_en && found;

  always_comb begin
    bus.req_ready = '0;
    bus.mul_valid = accept;
    bus.mul_a     = '0;
    bus.mul_b     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (accept && win == IDW'(i)) begin
        bus.req_ready[i] = 1'b1;
        bus.mul_a        = bus.req_a[i*WIDTH +: WIDTH];
        bus.mul_b        = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (bus.halt_req) state_d = DRAIN;
      DRAIN: begin
        if (!bus.halt_req) state_d = RUN;
        else if (!any_vld) state_d = HALTED;
      end
      HALTED:  if (!bus.halt_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  fp_arb_tag_pipe #(.IDW(IDW), .LAT(MUL_LAT)) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (accept),
    .in_id   (win),
    .out_vld (last_vld),
    .out_id  (last_id),
    .any_vld (any_vld)
  );

  assign bus.rsp_valid = (reset && last_vld) ? (NUM_REQ'(1) << last_id) : '0;
  assign bus.rsp_data  = (reset && last_vld) ? bus.mul_result : '0;
  assign bus.busy      = reset && any_vld;
  assign bus.halted    = reset && (state_q == HALTED);

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Randomized + directed bench for fp_mul_arbiter against a scoreboard model
// (winner search by plain modular scan, in-flight ops as a queue with due cycles).
module tb_fp_mul_arbiter;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned MUL_LAT = 3;
  localparam int unsigned NCYC    = 4000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp_mul_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

  fp_mul_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .MUL_LAT(MUL_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Stand-in multiplier: any deterministic function works since data passes through.
  function automatic logic [WIDTH-1:0] fmul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return a ^ {b[15:0], b[31:16]} ^ 32'h5a5a_0f0f;
  endfunction

  logic [WIDTH-1:0] stub_pipe [MUL_LAT];
  always @(posedge clk) begin
    stub_pipe[0] <= fmul(bus.mul_a, bus.mul_b);
    for (int i = 1; i < MUL_LAT; i++) stub_pipe[i] <= stub_pipe[i-1];
  end
  assign bus.mul_result = stub_pipe[MUL_LAT-1];

  typedef struct {
    int               id;
    logic [WIDTH-1:0] data;
    int unsigned      due;
  } op_t;

  op_t              sb [$];
  int unsigned      cyc;
  int unsigned      n_checks = 0;
  int unsigned      n_fail   = 0;
  int               m_rr;
  int               mode;      // 0 granting, 1 draining, 2 quiesced
  logic [WIDTH-1:0] op_a [NUM_REQ];
  logic [WIDTH-1:0] op_b [NUM_REQ];
  logic [NUM_REQ-1:0] pend;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial begin
    logic [NUM_REQ-1:0] v;
    logic               h, hq, r;
    int                 win, idx;
    logic [NUM_REQ-1:0] exp_ready, exp_rv;
    logic [WIDTH-1:0]   exp_a, exp_b, exp_rd;
    logic               exp_busy, exp_halted;

    reset         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.halt_req  = 1'b0;
    pend          = '0;
    m_rr          = NUM_REQ - 1;
    mode          = 0;
    hq            = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin op_a[i] = '0; op_b[i] = '0; end

    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      // Operands only change when the requester is not waiting on a grant.
      for (int i = 0; i < NUM_REQ; i++)
        if (!pend[i]) begin op_a[i] = $urandom; op_b[i] = $urandom; end
      r = 1'b1; h = 1'b0; v = '0;
      if (cyc < 3) r = 1'b0;
      else if (cyc == 4) begin
        v = 4'b0001; op_a[0] = 32'h4000_0000; op_b[0] = 32'h4040_0000;
      end
      else if (cyc >= 6  && cyc < 14) v = 4'b1111;
      else if (cyc >= 16 && cyc < 24) v = 4'b1010;
      else if (cyc >= 24 && cyc < 53) begin v = 4'b1111; h = (cyc >= 26 && cyc < 46); end
      else if (cyc == 53) begin v = 4'b1111; r = 1'b0; end
      else if (cyc > 53) begin
        for (int i = 0; i < NUM_REQ; i++) v[i] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 9) == 0) v = '0;
        if ($urandom_range(0, 24) == 0) hq = ~hq;
        h = hq;
        r = ($urandom_range(0, 199) != 0);
      end
      reset         = r;
      bus.halt_req  = h;
      bus.req_valid = v;
      for (int i = 0; i < NUM_REQ; i++) begin
        bus.req_a[i*WIDTH +: WIDTH] = op_a[i];
        bus.req_b[i*WIDTH +: WIDTH] = op_b[i];
      end

      @(negedge clk);
      win = -1;
      if (r && mode == 0) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
`ifdef FP_MUL_ARB_FIXED_PRIO_EN
          idx = k - 1;
`else
          idx = (m_rr + k) % NUM_REQ;
`endif
          if (win < 0 && v[idx]) win = idx;
        end
      end
      exp_ready = '0; exp_a = '0; exp_b = '0;
      if (win >= 0) begin exp_ready[win] = 1'b1; exp_a = op_a[win]; exp_b = op_b[win]; end
      exp_busy = r && (sb.size() > 0);
      exp_rv = '0; exp_rd = '0;
      if (r && sb.size() > 0 && sb[0].due == cyc) begin
        exp_rv[sb[0].id] = 1'b1;
        exp_rd = sb[0].data;
      end
      exp_halted = r && (mode == 2);

      check_eq("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      check_eq("mul_valid", 64'(bus.mul_valid), 64'(win >= 0));
      check_eq("mul_a",     64'(bus.mul_a),     64'(exp_a));
      check_eq("mul_b",     64'(bus.mul_b),     64'(exp_b));
      check_eq("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
      check_eq("rsp_data",  64'(bus.rsp_data),  64'(exp_rd));
      check_eq("busy",      64'(bus.busy),      64'(exp_busy));
      check_eq("halted",    64'(bus.halted),    64'(exp_halted));

      // Advance the model to the state after this cycle's rising edge.
      if (!r) begin
        sb.delete();
        m_rr = NUM_REQ - 1;
        mode = 0;
        pend = '0;
      end else begin
        if (sb.size() > 0 && sb[0].due == cyc) void'(sb.pop_front());
        if (win >= 0) begin
          sb.push_back('{id: win, data: fmul(exp_a, exp_b), due: cyc + MUL_LAT});
          m_rr = win;
        end
        case (mode)
          0:       if (h) mode = 1;
          1:       if (!h) mode = 0; else if (!exp_busy) mode = 2;
          default: if (!h) mode = 0;
        endcase
        pend = v;
        if (win >= 0) pend[win] = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
